// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dm_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    // Index width for a core count; never below one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// Core-side request bus and shared memory port of the data-memory arbiter.
interface dm_arbiter_if
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) ();

    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_we;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_ack;
    logic [DATA_W-1:0]           core_rdata;
    logic                        mem_en;
    logic                        mem_we;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;
    logic                        busy;

    // master: the arbiter itself; slave: the cores plus the memory it drives.
    modport master (
        input  core_req, core_we, core_addr, core_wdata, mem_rdata,
        output core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport slave (
        output core_req, core_we, core_addr, core_wdata, mem_rdata,
        input  core_ack, core_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dm_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, wrapping.
module rr_pick
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int IDX_W     = idx_width(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     last_grant,
    output logic                 found,
    output logic [IDX_W-1:0]     winner
);

    logic [IDX_W-1:0] cand [NUM_CORES];

    // cand[k] is the core k+1 places after the last grant.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(last_grant) + 1 + gi) % NUM_CORES);
        end
    endgenerate

    // Scan from the far end so the nearest candidate overwrites the rest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                found  = 1'b1;
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one data-memory port among the cluster cores.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    dm_arbiter_if.master bus
);

    localparam int IDX_W = idx_width(NUM_CORES);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] ACK   = ST_ACK;

    logic [1:0]           state_reg;
    logic [1:0]           state_next;
    logic [IDX_W-1:0]     grant_reg;
    logic [IDX_W-1:0]     last_grant_reg;
    logic                 we_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [DATA_W-1:0]    rdata_reg;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [ADDR_W-1:0]    addr_arr  [NUM_CORES];
    logic [DATA_W-1:0]    wdata_arr [NUM_CORES];
    logic [NUM_CORES-1:0] ack_vec;
    logic                 issue;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.core_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.core_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_pick #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req        (bus.core_req),
        .last_grant (last_grant_reg),
        .found      (pick_found),
        .winner     (pick_idx)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_found) state_next = ISSUE;
            ISSUE:   state_next = we_reg ? ACK : WAIT;
            WAIT:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Requests are only looked at in IDLE; the winner's fields are frozen here.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= IDX_W'(NUM_CORES - 1);
            grant_reg      <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            rdata_reg      <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && pick_found) begin
                grant_reg <= pick_idx;
                we_reg    <= bus.core_we[pick_idx];
                addr_reg  <= addr_arr[pick_idx];
                wdata_reg <= wdata_arr[pick_idx];
            end
            if (state_reg == WAIT) begin
                rdata_reg <= bus.mem_rdata;
            end
            if (state_reg == ACK) begin
                last_grant_reg <= grant_reg;
            end
        end
    end

    always_comb begin
        ack_vec = '0;
        if (state_reg == ACK) begin
            ack_vec[grant_reg] = 1'b1;
        end
    end

    assign issue          = (state_reg == ISSUE);
    assign bus.mem_en     = issue;
    assign bus.mem_we     = issue & we_reg;
    assign bus.mem_addr   = issue ? addr_reg  : '0;
    assign bus.mem_wdata  = issue ? wdata_reg : '0;
    assign bus.core_ack   = ack_vec;
    assign bus.core_rdata = rdata_reg;
    assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: expected transactions queued in grant order.
module tb_dm_arbiter;

    localparam int N = 4;

    typedef struct {
        int          core;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    dm_arbiter_if #(.NUM_CORES(N), .ADDR_W(16), .DATA_W(16)) bus ();

    dm_arbiter #(.NUM_CORES(N), .ADDR_W(16), .DATA_W(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int issue_cyc = 0;
    bit issue_seen = 0;
    logic [15:0] last_rd = '0;
    logic [N-1:0] pend = '0;
    int reissue [N];
    logic [15:0] fair_addr [N];
    txn_t q [$];
    int grant_log [$];
    int ack_log [$];

    // Memory responder and the bench's own reference contents.
    logic [15:0] mem_store [65536];
    bit          mem_wr    [65536];
    logic [15:0] model     [65536];
    bit          model_wr  [65536];

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'h5A5A);
    endfunction

    always @(posedge clock) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_store[bus.mem_addr] <= bus.mem_wdata;
                mem_wr[bus.mem_addr]    <= 1'b1;
            end else begin
                bus.mem_rdata <= mem_wr[bus.mem_addr] ? mem_store[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_txn(input int c, input bit we, input logic [15:0] a, input logic [15:0] d);
        txn_t t;
        bus.core_req[c] = 1'b1;
        bus.core_we[c] = we;
        bus.core_addr[c*16 +: 16] = a;
        bus.core_wdata[c*16 +: 16] = d;
        t.core = c;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        if (we) begin
            model[a] = d;
            model_wr[a] = 1'b1;
            t.rdata = '0;
        end else begin
            t.rdata = model_wr[a] ? model[a] : init_val(a);
        end
        q.push_back(t);
    endtask

    // One cycle: observe at the falling edge, then act as the cores would.
    task automatic step();
        logic [N-1:0] acked;
        txn_t f;
        @(negedge clock);
        cyc++;
        issue_seen = 0;
        acked = bus.core_ack;
        if (bus.mem_en) begin
            issue_seen = 1;
            issue_cyc = cyc;
            chk("busy_issue", 32'(bus.busy), 32'd1);
            if (q.size() == 0) begin
                chk("issue_unexpected", 32'(bus.mem_addr), 32'hFFFF_FFFF);
            end else begin
                f = q[0];
                chk("mem_addr", 32'(bus.mem_addr), 32'(f.addr));
                chk("mem_we", 32'(bus.mem_we), 32'(f.we));
                if (f.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(f.wdata));
            end
        end else begin
            chk("idle_mem_zero", {15'd0, bus.mem_we, bus.mem_addr}, 32'd0);
            chk("idle_wdata_zero", 32'(bus.mem_wdata), 32'd0);
        end
        if (acked != '0) begin
            if (q.size() == 0) begin
                chk("ack_unexpected", 32'(acked), 32'd0);
            end else begin
                f = q.pop_front();
                chk("ack_onehot", 32'(acked), 32'd1 << f.core);
                chk("ack_latency", 32'(cyc - issue_cyc), f.we ? 32'd1 : 32'd2);
                if (!f.we) begin
                    chk("rdata", 32'(bus.core_rdata), 32'(f.rdata));
                    last_rd = f.rdata;
                end else begin
                    chk("rdata_hold", 32'(bus.core_rdata), 32'(last_rd));
                end
                grant_log.push_back(f.core);
                ack_log.push_back(cyc);
                $display("txn core=%0d we=%0b addr=%h wdata=%h rdata=%h cyc=%0d",
                         f.core, f.we, f.addr, f.wdata, bus.core_rdata, cyc);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (pend[i]) begin
                pend[i] = 1'b0;
                push_txn(i, 1'b0, fair_addr[i], 16'h0000);
                fair_addr[i] = fair_addr[i] + 16'd1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (acked[i]) begin
                bus.core_req[i] = 1'b0;
                if (reissue[i] > 0) begin
                    reissue[i]--;
                    pend[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q.size() != 0 || pend != '0) && n < budget) begin
            step();
            n++;
        end
        if (q.size() != 0 || pend != '0) begin
            chk("timeout_left", 32'(q.size()) + 32'(pend), 32'd0);
            q.delete();
            pend = '0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.core_req = '0;
        for (int i = 0; i < N; i++) reissue[i] = 0;
        pend = '0;
        step();
        step();
        reset_n = 1'b1;
        q.delete();
        last_rd = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.core_req = '0;
        bus.core_we = '0;
        bus.core_addr = '0;
        bus.core_wdata = '0;
        for (int i = 0; i < N; i++) begin
            reissue[i] = 0;
            fair_addr[i] = '0;
        end

        do_reset();
        chk("rst_ack", 32'(bus.core_ack), 32'd0);
        chk("rst_rdata", 32'(bus.core_rdata), 32'd0);
        chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);

        // Single read: core 2, address 0x0010.
        push_txn(2, 1'b0, 16'h0010, 16'h0000);
        step();
        chk("t1_mem_en", 32'(bus.mem_en), 32'd1);
        chk("t1_mem_addr", 32'(bus.mem_addr), 32'h0010);
        step();
        step();
        chk("t1_ack", 32'(bus.core_ack), 32'b0100);
        chk("t1_rdata", 32'(bus.core_rdata), 32'hBEEF);
        wait_idle(10);

        // All four cores write at once straight after reset.
        do_reset();
        grant_log.delete();
        ack_log.delete();
        for (int i = 0; i < N; i++) push_txn(i, 1'b1, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
        wait_idle(40);
        chk("t2_count", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < grant_log.size(); i++) chk("t2_order", 32'(grant_log[i]), 32'(i));
        for (int i = 1; i < ack_log.size(); i++) chk("t2_gap", 32'(ack_log[i] - ack_log[i-1]), 32'd3);

        // Cores 0 and 3 keep reading; grants must alternate.
        grant_log.delete();
        reissue[0] = 2;
        reissue[3] = 2;
        fair_addr[0] = 16'h0020;
        fair_addr[3] = 16'h0030;
        push_txn(0, 1'b0, fair_addr[0], 16'h0000);
        fair_addr[0] = fair_addr[0] + 16'd1;
        push_txn(3, 1'b0, fair_addr[3], 16'h0000);
        fair_addr[3] = fair_addr[3] + 16'd1;
        wait_idle(80);
        chk("t3_count", 32'(grant_log.size()), 32'd6);
        if (grant_log.size() > 0) chk("t3_first", 32'(grant_log[0]), 32'd0);
        for (int i = 1; i < grant_log.size(); i++) chk("t3_alternate", 32'(grant_log[i] != grant_log[i-1]), 32'd1);

        // A write leaves the last read data untouched, then the new value reads back.
        push_txn(1, 1'b0, 16'h1234, 16'h0000);
        wait_idle(20);
        push_txn(1, 1'b1, 16'h1234, 16'h5555);
        wait_idle(20);
        chk("t4_rdata_kept", 32'(bus.core_rdata), 32'h486E);
        push_txn(1, 1'b0, 16'h1234, 16'h0000);
        wait_idle(20);

        // Inputs changed after the grant must not reach the memory port.
        step();
        push_txn(2, 1'b1, 16'h0200, 16'h7777);
        @(posedge clock);
        #1;
        bus.core_addr[2*16 +: 16] = 16'hFFFF;
        bus.core_wdata[2*16 +: 16] = 16'h0000;
        step();
        chk("t5_addr_latched", 32'(bus.mem_addr), 32'h0200);
        wait_idle(20);
        push_txn(0, 1'b0, 16'h0200, 16'h0000);
        wait_idle(20);

        // Reset during the WAIT of a core-1 read.
        grant_log.delete();
        push_txn(1, 1'b0, 16'h0040, 16'h0000);
        for (int n = 0; n < 10 && !issue_seen; n++) step();
        chk("t6_issue_seen", 32'(issue_seen), 32'd1);
        step();
        chk("t6_wait_busy", 32'(bus.busy), 32'd1);
        reset_n = 1'b0;
        step();
        chk("t6_rst_ack", 32'(bus.core_ack), 32'd0);
        chk("t6_rst_mem_en", 32'(bus.mem_en), 32'd0);
        chk("t6_rst_busy", 32'(bus.busy), 32'd0);
        chk("t6_rst_rdata", 32'(bus.core_rdata), 32'd0);
        q.delete();
        last_rd = '0;
        push_txn(0, 1'b0, 16'h0050, 16'h0000);
        push_txn(1, 1'b0, 16'h0040, 16'h0000);
        step();
        reset_n = 1'b1;
        wait_idle(30);
        chk("t6_count", 32'(grant_log.size()), 32'd2);
        if (grant_log.size() == 2) begin
            chk("t6_first", 32'(grant_log[0]), 32'd0);
            chk("t6_second", 32'(grant_log[1]), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
